// File: rtl/drac_pkg.sv
// Shared CSR address map and event-select type for the HPM counter bank.
package drac_pkg;

  localparam logic [11:0] HPM_COUNTER_BASE    = 12'hB03;
  localparam logic [11:0] HPM_COUNTER_RO_BASE = 12'hC03;
  localparam logic [11:0] HPM_EVENT_BASE      = 12'h323;
  localparam logic [11:0] HPM_INHIBIT_ADDR    = 12'h320;

  typedef logic [7:0] hpm_event_sel_t;

endpackage

// File: rtl/hpm_counter_slice.sv
// One HPM counter with its event select and sticky OF bit; counts popcount of selected lanes.
// Updates every cycle with no stall; CSR writes override the same-cycle increment.
module hpm_counter_slice
  import drac_pkg::*;
#(
  parameter int NUM_EVENTS = 32,
  parameter int NUM_LANES  = 2,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [NUM_EVENTS*NUM_LANES-1:0] ev_i,
  input  logic                            inhibit_i,
  input  logic                            cnt_we_i,
  input  logic [CNT_WIDTH-1:0]            cnt_wdata_i,
  input  logic                            evt_we_i,
  input  hpm_event_sel_t                  sel_wdata_i,
  input  logic                            of_wdata_i,
  output logic [CNT_WIDTH-1:0]            cnt_o,
  output hpm_event_sel_t                  sel_o,
  output logic                            of_o
);

  localparam int IW = $clog2(NUM_LANES + 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  hpm_event_sel_t       sel_q, sel_d;
  logic                 of_q, of_d;
  logic [NUM_LANES-1:0] lanes;
  logic [IW-1:0]        inc;
  logic [CNT_WIDTH:0]   sum;

  // Selections at or beyond NUM_EVENTS match no entry and leave lanes at zero.
  always_comb begin
    lanes = '0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if (sel_q == hpm_event_sel_t'(e)) lanes = ev_i[e*NUM_LANES +: NUM_LANES];
    end
    inc = '0;
    for (int l = 0; l < NUM_LANES; l++) inc = inc + IW'(lanes[l]);
    if (sel_q == '0 || inhibit_i) inc = '0;
  end

  assign sum = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(inc);

  always_comb begin
    cnt_d = sum[CNT_WIDTH-1:0];
    of_d  = of_q | (sum[CNT_WIDTH] & ~cnt_we_i);
    sel_d = sel_q;
    if (cnt_we_i) cnt_d = cnt_wdata_i;
    if (evt_we_i) begin
      sel_d = sel_wdata_i;
      of_d  = of_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      sel_q <= '0;
      of_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      of_q  <= of_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sel_o = sel_q;
  assign of_o  = of_q;

endmodule

// File: rtl/hpm_event_counters.sv
// Configurable HPM counter bank on the csr_bsc perf interface; events registered then counted next edge.
// No backpressure: one update per counter per cycle, combinational CSR read.
module hpm_event_counters
  import drac_pkg::*;
#(
  parameter int NUM_COUNTERS = 8,
  parameter int NUM_EVENTS   = 32,
  parameter int NUM_LANES    = 2,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [11:0]                     addr_i,
  input  logic                            we_i,
  input  logic [63:0]                     data_i,
  output logic [63:0]                     data_o,
  input  logic [NUM_EVENTS*NUM_LANES-1:0] events_i,
  output logic                            ovf_irq_o
);

  logic [NUM_EVENTS*NUM_LANES-1:0] ev_q;
  logic [NUM_COUNTERS-1:0]         inhibit_q, inhibit_d;
  logic [NUM_COUNTERS-1:0]         cnt_we, evt_we, of;
  logic [CNT_WIDTH-1:0]            cnt [NUM_COUNTERS];
  hpm_event_sel_t                  sel [NUM_COUNTERS];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ev_q      <= '0;
      inhibit_q <= '0;
    end else begin
      ev_q      <= events_i;
      inhibit_q <= inhibit_d;
    end
  end

  // Address decode and read mux; mcountinhibit bit 3+i maps to counter i.
  always_comb begin
    data_o    = '0;
    cnt_we    = '0;
    evt_we    = '0;
    inhibit_d = inhibit_q;
    if (addr_i == HPM_INHIBIT_ADDR) begin
      data_o = 64'({inhibit_q, 3'b000});
      if (we_i) inhibit_d = data_i[3 +: NUM_COUNTERS];
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (addr_i == HPM_COUNTER_BASE + 12'(i)) begin
        data_o    = 64'(cnt[i]);
        cnt_we[i] = we_i;
      end
      if (addr_i == HPM_COUNTER_RO_BASE + 12'(i)) data_o = 64'(cnt[i]);
      if (addr_i == HPM_EVENT_BASE + 12'(i)) begin
        data_o    = {of[i], 55'b0, sel[i]};
        evt_we[i] = we_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slice
    hpm_counter_slice #(
      .NUM_EVENTS(NUM_EVENTS),
      .NUM_LANES (NUM_LANES),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_slice (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .ev_i       (ev_q),
      .inhibit_i  (inhibit_q[g]),
      .cnt_we_i   (cnt_we[g]),
      .cnt_wdata_i(data_i[CNT_WIDTH-1:0]),
      .evt_we_i   (evt_we[g]),
      .sel_wdata_i(data_i[7:0]),
      .of_wdata_i (data_i[63]),
      .cnt_o      (cnt[g]),
      .sel_o      (sel[g]),
      .of_o       (of[g])
    );
  end

  assign ovf_irq_o = |of;

endmodule

// File: tb/tb_hpm_event_counters.sv
// Directed bench for hpm_event_counters: hand-computed expected reads after each scenario.
module tb_hpm_event_counters;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [11:0] addr_i;
  logic        we_i;
  logic [63:0] data_i;
  logic [63:0] data_o;
  logic [63:0] events_i;
  logic        ovf_irq_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0] rv;

  hpm_event_counters #(
    .NUM_COUNTERS(8),
    .NUM_EVENTS  (32),
    .NUM_LANES   (2),
    .CNT_WIDTH   (64)
  ) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .events_i (events_i),
    .ovf_irq_o(ovf_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    cyc();
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [63:0] v);
    addr_i = a;
    we_i   = 1'b0;
    #1;
    v = data_o;
  endtask

  task automatic test_reset();
    logic [11:0] a;
    rstn_i   = 1'b0;
    we_i     = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    events_i = '0;
    #2;
    vec_cnt++;
    if (ovf_irq_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_irq: got %b expected 0", ovf_irq_o);
    end
    for (int i = 0; i < 25; i++) begin
      a = (i < 8) ? 12'hB03 + 12'(i) : (i < 16) ? 12'hC03 + 12'(i - 8) :
          (i < 24) ? 12'h323 + 12'(i - 16) : 12'h320;
      rd(a, rv);
      vec_cnt++;
      if (rv !== 64'h0) begin
        err_cnt++;
        $display("FAIL reset_read[%h]: got %h expected 0", a, rv);
      end
    end
    cyc();
    cyc();
    rstn_i = 1'b1;
    cyc();
  endtask

  task automatic test_multi_lane();
    csr_write(12'h323, 64'd5);
    rd(12'h323, rv);
    vec_cnt++;
    if (rv !== 64'd5) begin err_cnt++; $display("FAIL ml_sel: got %h expected 5", rv); end
    events_i = 64'hC00;
    cyc(); cyc(); cyc();
    events_i = '0;
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd4) begin err_cnt++; $display("FAIL ml_mid: got %0d expected 4", rv); end
    cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd6) begin err_cnt++; $display("FAIL ml_cnt: got %0d expected 6", rv); end
    rd(12'hC03, rv);
    vec_cnt++;
    if (rv !== 64'd6) begin err_cnt++; $display("FAIL ml_alias: got %0d expected 6", rv); end
    cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd6) begin err_cnt++; $display("FAIL ml_hold: got %0d expected 6", rv); end
  endtask

  task automatic test_inhibit();
    events_i = 64'hC00;
    cyc(); cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd8) begin err_cnt++; $display("FAIL inh_pre: got %0d expected 8", rv); end
    csr_write(12'h320, 64'h8);
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd10) begin err_cnt++; $display("FAIL inh_edge: got %0d expected 10", rv); end
    cyc(); cyc(); cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd10) begin err_cnt++; $display("FAIL inh_frozen: got %0d expected 10", rv); end
    rd(12'h320, rv);
    vec_cnt++;
    if (rv !== 64'h8) begin err_cnt++; $display("FAIL inh_reg: got %h expected 8", rv); end
    csr_write(12'h320, 64'h0);
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd10) begin err_cnt++; $display("FAIL inh_clr_edge: got %0d expected 10", rv); end
    cyc(); cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd14) begin err_cnt++; $display("FAIL inh_resume: got %0d expected 14", rv); end
    events_i = '0;
    cyc(); cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd16) begin err_cnt++; $display("FAIL inh_drain: got %0d expected 16", rv); end
  endtask

  task automatic test_back_to_back();
    events_i = 64'hC00;
    cyc();
    csr_write(12'hB03, 64'd100);
    events_i = '0;
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd100) begin err_cnt++; $display("FAIL col_write: got %0d expected 100", rv); end
    cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd102) begin err_cnt++; $display("FAIL col_next: got %0d expected 102", rv); end
    cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd102) begin err_cnt++; $display("FAIL col_hold: got %0d expected 102", rv); end
  endtask

  task automatic test_overflow();
    csr_write(12'h324, 64'd7);
    csr_write(12'hB04, 64'hFFFF_FFFF_FFFF_FFFF);
    events_i = 64'h4000;
    cyc();
    events_i = '0;
    cyc();
    rd(12'hB04, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL ovf_cnt: got %h expected 0", rv); end
    rd(12'h324, rv);
    vec_cnt++;
    if (rv !== 64'h8000_0000_0000_0007) begin
      err_cnt++; $display("FAIL ovf_of: got %h expected 8000000000000007", rv);
    end
    vec_cnt++;
    if (ovf_irq_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_irq: got %b expected 1", ovf_irq_o); end
    csr_write(12'h325, 64'd7);
    csr_write(12'hB05, 64'hFFFF_FFFF_FFFF_FFFF);
    events_i = 64'hC000;
    cyc();
    events_i = '0;
    cyc();
    rd(12'hB05, rv);
    vec_cnt++;
    if (rv !== 64'd1) begin err_cnt++; $display("FAIL ovf_wrap2: got %h expected 1", rv); end
    rd(12'hB04, rv);
    vec_cnt++;
    if (rv !== 64'd2) begin err_cnt++; $display("FAIL ovf_cnt4: got %h expected 2", rv); end
    rd(12'h324, rv);
    vec_cnt++;
    if (rv !== 64'h8000_0000_0000_0007) begin
      err_cnt++; $display("FAIL ovf_sticky: got %h expected 8000000000000007", rv);
    end
    csr_write(12'h325, 64'd7);
    rd(12'h325, rv);
    vec_cnt++;
    if (rv !== 64'd7) begin err_cnt++; $display("FAIL ovf_clr5: got %h expected 7", rv); end
    vec_cnt++;
    if (ovf_irq_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_irq_one: got %b expected 1", ovf_irq_o); end
    csr_write(12'h324, 64'd7);
    vec_cnt++;
    if (ovf_irq_o !== 1'b0) begin err_cnt++; $display("FAIL ovf_irq_clr: got %b expected 0", ovf_irq_o); end
    // Event-register write lands on the same edge as the wrap and must win.
    csr_write(12'hB04, 64'hFFFF_FFFF_FFFF_FFFF);
    events_i = 64'h4000;
    cyc();
    events_i = '0;
    csr_write(12'h324, 64'd7);
    rd(12'hB04, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL ovf_coll_cnt: got %h expected 0", rv); end
    vec_cnt++;
    if (ovf_irq_o !== 1'b0) begin err_cnt++; $display("FAIL ovf_coll_irq: got %b expected 0", ovf_irq_o); end
    csr_write(12'h326, 64'h8000_0000_0000_0000);
    vec_cnt++;
    if (ovf_irq_o !== 1'b1) begin err_cnt++; $display("FAIL of_write_irq: got %b expected 1", ovf_irq_o); end
    rd(12'h326, rv);
    vec_cnt++;
    if (rv !== 64'h8000_0000_0000_0000) begin
      err_cnt++; $display("FAIL of_write_rd: got %h expected 8000000000000000", rv);
    end
    csr_write(12'h326, 64'd0);
    vec_cnt++;
    if (ovf_irq_o !== 1'b0) begin err_cnt++; $display("FAIL of_clear_irq: got %b expected 0", ovf_irq_o); end
  endtask

  task automatic test_illegal();
    csr_write(12'hC03, 64'd1234);
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd102) begin err_cnt++; $display("FAIL ro_write: got %0d expected 102", rv); end
    rd(12'hC03, rv);
    vec_cnt++;
    if (rv !== 64'd102) begin err_cnt++; $display("FAIL ro_read: got %0d expected 102", rv); end
    csr_write(12'h323, 64'h7FFF_FFFF_FFFF_FF05);
    rd(12'h323, rv);
    vec_cnt++;
    if (rv !== 64'd5) begin err_cnt++; $display("FAIL evt_mask: got %h expected 5", rv); end
    csr_write(12'hB20, 64'd55);
    rd(12'hB20, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL unmapped_b20: got %h expected 0", rv); end
    rd(12'hB0B, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL unmapped_b0b: got %h expected 0", rv); end
    rd(12'h32B, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL unmapped_32b: got %h expected 0", rv); end
    csr_write(12'h326, 64'd32);
    rd(12'h326, rv);
    vec_cnt++;
    if (rv !== 64'h20) begin err_cnt++; $display("FAIL sel_range_rd: got %h expected 20", rv); end
    events_i = '1;
    cyc(); cyc(); cyc();
    events_i = '0;
    cyc(); cyc();
    rd(12'hB06, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL sel_range_cnt: got %h expected 0", rv); end
    rd(12'hB07, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL sel_zero_cnt: got %h expected 0", rv); end
    csr_write(12'h320, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h320, rv);
    vec_cnt++;
    if (rv !== 64'h7F8) begin err_cnt++; $display("FAIL inh_mask: got %h expected 7f8", rv); end
    csr_write(12'h320, 64'd0);
  endtask

  task automatic test_reset_mid();
    logic [11:0] a;
    csr_write(12'h326, 64'h8000_0000_0000_0005);
    events_i = '1;
    cyc(); cyc();
    #1;
    rstn_i = 1'b0;
    #1;
    vec_cnt++;
    if (ovf_irq_o !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_irq: got %b expected 0", ovf_irq_o); end
    for (int i = 0; i < 25; i++) begin
      a = (i < 8) ? 12'hB03 + 12'(i) : (i < 16) ? 12'hC03 + 12'(i - 8) :
          (i < 24) ? 12'h323 + 12'(i - 16) : 12'h320;
      rd(a, rv);
      vec_cnt++;
      if (rv !== 64'h0) begin
        err_cnt++;
        $display("FAIL rst_mid_read[%h]: got %h expected 0", a, rv);
      end
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    cyc(); cyc(); cyc();
    rd(12'hB03, rv);
    vec_cnt++;
    if (rv !== 64'd0) begin err_cnt++; $display("FAIL rst_mid_after: got %h expected 0", rv); end
    events_i = '0;
  endtask

  initial begin
    test_reset();
    test_multi_lane();
    test_inhibit();
    test_back_to_back();
    test_overflow();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
